// File: rtl/cluster_data_port_arbiter.sv
// cluster_data_port_arbiter: round-robin share of one cluster data slave port with in-order response routing
module cluster_data_port_arbiter #(
    parameter int NumReq         = 8,
    parameter int MaxOutstanding = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumReq-1:0][69:0]               req_i,
    output logic [NumReq-1:0][33:0]               rsp_o,
    output logic [69:0]                           slv_req_o,
    input  logic [33:0]                           slv_rsp_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
    output logic                                  err_o
);
    localparam int IW = $clog2(NumReq);
    localparam int PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
    localparam int CW = $clog2(MaxOutstanding + 1);

    logic [IW-1:0] rr_ptr, lock_id, rr_pick, sel, head;
    logic          lock_vld, rr_any, cand, fwd, hs, pop;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [IW-1:0] ids [MaxOutstanding];

    // descending scan so the requester closest to rr_ptr wins
    always_comb begin
        rr_any  = 1'b0;
        rr_pick = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_i[(int'(rr_ptr) + k) % NumReq][69]) begin
                rr_any  = 1'b1;
                rr_pick = IW'((int'(rr_ptr) + k) % NumReq);
            end
        end
    end

    assign sel           = lock_vld ? lock_id : rr_pick;
    assign cand          = lock_vld ? req_i[lock_id][69] : rr_any;
    assign fwd           = cand && (count < CW'(MaxOutstanding));
    assign hs            = fwd && slv_rsp_i[33];
    assign pop           = slv_rsp_i[0] && (count != '0);
    assign head          = ids[rd_ptr];
    assign slv_req_o     = fwd ? req_i[sel] : '0;
    assign outstanding_o = count;

    always_comb begin
        rsp_o = '0;
        for (int p = 0; p < NumReq; p++)
            rsp_o[p] = {hs && (sel == IW'(p)), slv_rsp_i[32:1], pop && (head == IW'(p))};
    end

    always_ff @(posedge clk_i) begin
        if (hs) ids[wr_ptr] <= sel;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_id  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_o    <= 1'b0;
        end else begin
            if (hs) begin
                wr_ptr <= (wr_ptr == PW'(MaxOutstanding - 1)) ? '0 : wr_ptr + 1'b1;
                rr_ptr <= (sel == IW'(NumReq - 1)) ? '0 : sel + 1'b1;
            end
            // a dropped locked request leaves fwd low, which releases the lock
            lock_vld <= fwd && !hs;
            if (fwd && !hs) lock_id <= sel;
            if (pop) rd_ptr <= (rd_ptr == PW'(MaxOutstanding - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(hs) - CW'(pop);
            err_o <= slv_rsp_i[0] && (count == '0);
        end
    end
endmodule

// File: tb/tb_cluster_data_port_arbiter.sv
// tb_cluster_data_port_arbiter: table, directed and random checks against a queue-based reference model
module tb_cluster_data_port_arbiter;
    localparam int N  = 8;
    localparam int MO = 4;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic [N-1:0][69:0]   req_i;
    logic [N-1:0][33:0]   rsp_o;
    logic [69:0]          slv_req_o;
    logic [33:0]          slv_rsp_i;
    logic [2:0]           outstanding_o;
    logic                 err_o;

    cluster_data_port_arbiter #(.NumReq(N), .MaxOutstanding(MO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .rsp_o(rsp_o),
        .slv_req_o(slv_req_o), .slv_rsp_i(slv_rsp_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    logic [68:0] pay [N];
    int checks = 0, errors = 0;
    int rr = 0, lock = -1;
    int q[$];
    bit m_err = 1'b0;

    typedef struct {
        logic [N-1:0] mask;
        bit           gnt;
        bit           rv;
        int           exp_gnt;
        int           exp_rv;
        int           exp_out;
        bit           exp_err;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic checki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int gnt_port();
        for (int p = 0; p < N; p++) if (rsp_o[p][33]) return p;
        return -1;
    endfunction

    function automatic int rv_port();
        for (int p = 0; p < N; p++) if (rsp_o[p][0]) return p;
        return -1;
    endfunction

    task automatic cycle(input logic [N-1:0] mask, input bit g, input bit rv, input logic [31:0] rd);
        int sel, head;
        bit cand, fwd, hs, pop;
        logic [69:0] es;
        logic [N-1:0][33:0] er;
        @(negedge clk);
        for (int p = 0; p < N; p++) req_i[p] = {mask[p], pay[p]};
        slv_rsp_i = {g, rd, rv};
        #1;
        sel = 0;
        cand = 1'b0;
        if (lock >= 0) begin
            sel = lock;
            cand = mask[lock];
        end else begin
            for (int k = 0; k < N; k++)
                if (!cand && mask[(rr + k) % N]) begin
                    cand = 1'b1;
                    sel = (rr + k) % N;
                end
        end
        fwd  = cand && (q.size() < MO);
        hs   = fwd && g;
        pop  = rv && (q.size() > 0);
        head = pop ? q[0] : -1;
        es   = fwd ? {1'b1, pay[sel]} : 70'b0;
        for (int p = 0; p < N; p++) er[p] = {hs && (sel == p), rd, pop && (head == p)};
        check("slv_req", 512'(slv_req_o), 512'(es));
        check("rsp", 512'(rsp_o), 512'(er));
        checki("outstanding", int'(outstanding_o), q.size());
        checki("err", int'(err_o), int'(m_err));
        m_err = rv && (q.size() == 0);
        if (pop) void'(q.pop_front());
        if (hs) begin
            q.push_back(sel);
            rr = (sel + 1) % N;
            lock = -1;
        end else begin
            lock = fwd ? sel : -1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        req_i = '0;
        slv_rsp_i = '0;
        @(negedge clk);
        rst_ni = 1'b1;
        rr = 0;
        lock = -1;
        q.delete();
        m_err = 1'b0;
    endtask

    initial begin
        logic [N-1:0] lm;
        tbl[0] = '{N'(0),  1'b0, 1'b0, -1, -1, 0, 1'b0};
        tbl[1] = '{N'(8),  1'b1, 1'b0,  3, -1, 0, 1'b0};
        tbl[2] = '{N'(0),  1'b0, 1'b0, -1, -1, 1, 1'b0};
        tbl[3] = '{N'(0),  1'b0, 1'b1, -1,  3, 1, 1'b0};
        tbl[4] = '{N'(0),  1'b0, 1'b0, -1, -1, 0, 1'b0};
        tbl[5] = '{N'(0),  1'b0, 1'b1, -1, -1, 0, 1'b0};
        tbl[6] = '{N'(0),  1'b0, 1'b0, -1, -1, 0, 1'b1};
        tbl[7] = '{N'(0),  1'b0, 1'b0, -1, -1, 0, 1'b0};
        for (int p = 0; p < N; p++) pay[p] = {$urandom, 1'($urandom), $urandom, 4'($urandom)};
        pay[3] = {32'h1C00_0010, 1'b0, 32'h0, 4'hF};
        req_i = '0;
        slv_rsp_i = '0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].mask, tbl[i].gnt, tbl[i].rv, 32'hDEAD_BEEF);
            checki("tbl_gnt", gnt_port(), tbl[i].exp_gnt);
            checki("tbl_rv", rv_port(), tbl[i].exp_rv);
            checki("tbl_out", int'(outstanding_o), tbl[i].exp_out);
            checki("tbl_err", int'(err_o), int'(tbl[i].exp_err));
            if (tbl[i].exp_rv >= 0) check("tbl_rdata", 512'(rsp_o[tbl[i].exp_rv][32:1]), 512'(32'hDEAD_BEEF));
        end

        do_reset();
        for (int c = 0; c <= N; c++) begin
            cycle('1, 1'b1, c > 0, 32'hA000_0000 + 32'(c));
            checki("rr_order", gnt_port(), c % N);
            if (c > 0) checki("rr_resp", rv_port(), (c - 1) % N);
        end

        do_reset();
        cycle(N'(8), 1'b1, 1'b0, 32'h0);
        lm = N'(36);
        for (int c = 0; c < 4; c++) begin
            cycle(c == 0 ? lm : lm | N'(16), c == 3, 1'b0, 32'h0);
            check("lock_add", 512'(slv_req_o[68:37]), 512'(pay[5][68:37]));
        end
        checki("lock_gnt", gnt_port(), 5);
        cycle(N'(20), 1'b1, 1'b0, 32'h0);
        checki("after_lock_gnt", gnt_port(), 2);
        cycle(N'(16), 1'b1, 1'b0, 32'h0);
        checki("after_lock_gnt2", gnt_port(), 4);

        cycle('1, 1'b1, 1'b0, 32'h0);
        checki("full_req", int'(slv_req_o[69]), 0);
        checki("full_out", int'(outstanding_o), 4);
        cycle('1, 1'b1, 1'b1, 32'h55);
        checki("full_pop_req", int'(slv_req_o[69]), 0);
        checki("full_pop_rv", rv_port(), 3);
        cycle('1, 1'b1, 1'b0, 32'h0);
        checki("full_resume_req", int'(slv_req_o[69]), 1);
        checki("full_resume_gnt", gnt_port(), 5);
        cycle('0, 1'b0, 1'b1, 32'h1);
        cycle('0, 1'b0, 1'b1, 32'h2);
        checki("pre_reset_out", int'(outstanding_o), 3);

        do_reset();
        cycle('0, 1'b0, 1'b0, 32'h0);
        checki("reset_out", int'(outstanding_o), 0);
        cycle('0, 1'b0, 1'b1, 32'h0);
        checki("spur_rv", rv_port(), -1);
        cycle('1, 1'b1, 1'b0, 32'h0);
        checki("reset_first_gnt", gnt_port(), 0);
        checki("spur_err", int'(err_o), 1);

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            for (int p = 0; p < N; p++) pay[p] = {$urandom, 1'($urandom), $urandom, 4'($urandom)};
            cycle(($urandom_range(0, 7) == 0) ? '1 : N'($urandom & $urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
